// File: rtl/wave_gen.sv
// Tick-driven test-tone generator (square/saw/triangle/noise); tick_i rise -> step next edge -> valid_o one edge later.
// Backpressure: an unconsumed sample is held; a newer sample arriving while held is dropped and flags sticky overrun_o.
module wave_gen #(
    parameter int DW = 16,
    parameter int PW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          tick_i,
    input  logic          en_i,
    input  logic [1:0]    wave_sel_i,
    input  logic          ready_i,
    output logic [DW-1:0] sample_o,
    output logic          valid_o,
    output logic          sof_o,
    output logic          overrun_o
);

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_NOISE  = 2'd3
    } wave_e;

    localparam logic [DW-1:0] SQ_POS = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] SQ_NEG = {1'b1, {(DW-2){1'b0}}, 1'b1};

    logic          tick_q;
    logic          armed;
    logic [PW-1:0] phase;
    wave_e         sel_q;
    logic [15:0]   lfsr;
    logic          load_pend;

    logic          step;
    logic          lfsr_fb;
    logic [PW-2:0] tri_t;
    logic [PW-1:0] saw_w;
    logic [PW-1:0] tri_w;
    logic [DW-1:0] sample_nxt;
    logic          sof_nxt;

    always_comb begin
        // armed blocks a step when tick_i is already high as reset releases or en_i rises
        step       = tick_i & ~tick_q & en_i & armed;
        lfsr_fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
        tri_t      = phase[PW-1] ? ~phase[PW-2:0] : phase[PW-2:0];
        saw_w      = {~phase[PW-1], phase[PW-2:0]};
        tri_w      = {~tri_t[PW-2], tri_t[PW-3:0], 1'b0};
        sof_nxt    = (phase == '0);
        sample_nxt = '0;
        case (sel_q)
            WAVE_SQUARE: sample_nxt = phase[PW-1] ? SQ_NEG : SQ_POS;
            WAVE_SAW:    sample_nxt = DW'(saw_w) << (DW - PW);
            WAVE_TRI:    sample_nxt = DW'(tri_w) << (DW - PW);
            WAVE_NOISE:  sample_nxt = lfsr[15 -: DW];
            default:     sample_nxt = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_q    <= 1'b0;
            armed     <= 1'b0;
            phase     <= '0;
            sel_q     <= WAVE_SQUARE;
            lfsr      <= 16'hACE1;
            load_pend <= 1'b0;
        end else begin
            tick_q <= tick_i;
            if (!en_i)
                armed <= 1'b0;
            else if (!tick_i)
                armed <= 1'b1;

            if (!en_i) begin
                phase     <= '0;
                sel_q     <= wave_e'(wave_sel_i);
                load_pend <= 1'b0;
            end else begin
                load_pend <= step;
                if (step) begin
                    phase <= phase + 1'b1;
                    if (sel_q == WAVE_NOISE)
                        lfsr <= {lfsr_fb, lfsr[15:1]};
                    // waveform changes only take effect at a period boundary
                    if (phase == '1)
                        sel_q <= wave_e'(wave_sel_i);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_o  <= '0;
            valid_o   <= 1'b0;
            sof_o     <= 1'b0;
            overrun_o <= 1'b0;
        end else if (load_pend) begin
            if (valid_o && !ready_i) begin
                overrun_o <= 1'b1;
            end else begin
                sample_o <= sample_nxt;
                sof_o    <= sof_nxt;
                valid_o  <= 1'b1;
            end
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wave_gen.sv
// Directed bench for wave_gen (DW=16, PW=8): full-period sweeps checked against a vector table, plus handshake/reset sequences.
module tb_wave_gen;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        tick_i = 1'b0;
    logic        en_i = 1'b0;
    logic [1:0]  wave_sel_i = 2'd0;
    logic        ready_i = 1'b1;
    logic [15:0] sample_o;
    logic        valid_o;
    logic        sof_o;
    logic        overrun_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    wave_gen #(.DW(16), .PW(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .tick_i     (tick_i),
        .en_i       (en_i),
        .wave_sel_i (wave_sel_i),
        .ready_i    (ready_i),
        .sample_o   (sample_o),
        .valid_o    (valid_o),
        .sof_o      (sof_o),
        .overrun_o  (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  sel;
        int          ph;
        logic [15:0] smp;
        logic        sof;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] obs_s[4][256];
    logic        obs_v[4][256];
    logic        obs_f[4][256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // One tick period of 5 cycles; outputs sampled two edges after the rise.
    task automatic tick_capture(output logic [15:0] s, output logic v, output logic f);
        @(negedge clk_i);
        tick_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        s = sample_o;
        v = valid_o;
        f = sof_o;
        tick_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic start(input logic [1:0] sel);
        do_reset();
        en_i = 1'b0;
        wave_sel_i = sel;
        tick_i = 1'b0;
        @(negedge clk_i);
        en_i = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] s;
        logic        v;
        logic        f;
        int          bad;

        // saw
        vecs.push_back('{2'd1,   1, 16'h8100, 1'b0});
        vecs.push_back('{2'd1, 128, 16'h0000, 1'b0});
        vecs.push_back('{2'd1, 255, 16'h7F00, 1'b0});
        vecs.push_back('{2'd1,   0, 16'h8000, 1'b1});
        // square
        vecs.push_back('{2'd0,   1, 16'h7FFF, 1'b0});
        vecs.push_back('{2'd0, 127, 16'h7FFF, 1'b0});
        vecs.push_back('{2'd0, 128, 16'h8001, 1'b0});
        vecs.push_back('{2'd0, 255, 16'h8001, 1'b0});
        vecs.push_back('{2'd0,   0, 16'h7FFF, 1'b1});
        // triangle
        vecs.push_back('{2'd2,   1, 16'h8200, 1'b0});
        vecs.push_back('{2'd2,  64, 16'h0000, 1'b0});
        vecs.push_back('{2'd2, 127, 16'h7E00, 1'b0});
        vecs.push_back('{2'd2, 128, 16'h7E00, 1'b0});
        vecs.push_back('{2'd2, 255, 16'h8000, 1'b0});
        vecs.push_back('{2'd2,   0, 16'h8000, 1'b1});
        // noise: ACE1 -> 5670 -> AB38 -> 559C
        vecs.push_back('{2'd3,   1, 16'h5670, 1'b0});
        vecs.push_back('{2'd3,   2, 16'hAB38, 1'b0});
        vecs.push_back('{2'd3,   3, 16'h559C, 1'b0});

        do_reset();
        @(negedge clk_i);
        check("reset_sample",  32'(sample_o),  32'h0);
        check("reset_valid",   32'(valid_o),   32'h0);
        check("reset_sof",     32'(sof_o),     32'h0);
        check("reset_overrun", 32'(overrun_o), 32'h0);

        for (int w = 0; w < 4; w++) begin
            start(2'(w));
            bad = 0;
            for (int i = 1; i <= 256; i++) begin
                tick_capture(s, v, f);
                obs_s[w][i % 256] = s;
                obs_v[w][i % 256] = v;
                obs_f[w][i % 256] = f;
                if (v !== 1'b1) bad++;
            end
            check($sformatf("sweep%0d_valid_missing", w), 32'(bad), 32'd0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            check($sformatf("vec%0d_sel%0d_ph%0d_sample", i, vecs[i].sel, vecs[i].ph),
                  32'(obs_s[vecs[i].sel][vecs[i].ph]), 32'(vecs[i].smp));
            check($sformatf("vec%0d_sel%0d_ph%0d_sof", i, vecs[i].sel, vecs[i].ph),
                  32'(obs_f[vecs[i].sel][vecs[i].ph]), 32'(vecs[i].sof));
        end

        // latency: valid_o rises exactly two edges after tick_i is first seen high
        start(2'd1);
        @(negedge clk_i);
        tick_i = 1'b1;
        @(negedge clk_i);
        check("latency_valid_early", 32'(valid_o), 32'h0);
        @(negedge clk_i);
        check("latency_valid_on_time", 32'(valid_o), 32'h1);
        check("latency_sample", 32'(sample_o), 32'h8100);
        tick_i = 1'b0;
        @(negedge clk_i);
        check("latency_consumed", 32'(valid_o), 32'h0);

        // backpressure across two steps
        start(2'd1);
        ready_i = 1'b0;
        tick_capture(s, v, f);
        check("bp_first_valid",  32'(v), 32'h1);
        check("bp_first_sample", 32'(s), 32'h8100);
        tick_capture(s, v, f);
        check("bp_held_sample", 32'(s), 32'h8100);
        check("bp_overrun_set", 32'(overrun_o), 32'h1);
        ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_valid_drop", 32'(valid_o), 32'h0);
        tick_capture(s, v, f);
        check("bp_phase_advanced", 32'(s), 32'h8300);
        check("bp_overrun_sticky", 32'(overrun_o), 32'h1);

        // saw -> square requested at phase 50 takes effect at phase 0
        start(2'd1);
        for (int i = 1; i <= 50; i++) tick_capture(s, v, f);
        wave_sel_i = 2'd0;
        for (int i = 51; i <= 200; i++) tick_capture(s, v, f);
        check("switch_ph200_still_saw", 32'(s), 32'h4800);
        for (int i = 201; i <= 255; i++) tick_capture(s, v, f);
        check("switch_ph255_saw", 32'(s), 32'h7F00);
        tick_capture(s, v, f);
        check("switch_ph0_square", 32'(s), 32'h7FFF);
        check("switch_ph0_sof", 32'(f), 32'h1);
        tick_capture(s, v, f);
        check("switch_ph1_square", 32'(s), 32'h7FFF);

        // reset with a pending sample and tick_i held high
        start(2'd1);
        ready_i = 1'b0;
        tick_capture(s, v, f);
        check("rst_pre_valid", 32'(v), 32'h1);
        @(negedge clk_i);
        tick_i = 1'b1;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_mid_valid",  32'(valid_o),  32'h0);
        check("rst_mid_sample", 32'(sample_o), 32'h0);
        rst_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 6; i++) @(negedge clk_i);
        check("rst_tick_high_no_step", 32'(valid_o), 32'h0);
        tick_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        tick_capture(s, v, f);
        check("rst_after_retick_valid",  32'(v), 32'h1);
        check("rst_after_retick_sample", 32'(s), 32'h7FFF);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
